// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register with valid/ready flow control, bubble
// collapsing and synchronous flush. Define PIPE_REG_OCC_EN to add the occ counter.
module pipe_reg_chain #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
`ifdef PIPE_REG_OCC_EN
    ,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [CNT_W-1:0] occ
`endif
);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            go;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic                        accept;

    // A stage may advance if it is empty or the stage ahead advances; this
    // lets any bubble absorb its upstream neighbour even while the output stalls.
    always_comb begin
        go          = '0;
        go[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            go[DEPTH-1-k] = ~v_q[DEPTH-1-k] | go[DEPTH-k];
        end
    end

    assign in_ready  = go[0] & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign accept    = in_valid & in_ready;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (go[0]) begin
                v_d[0] = accept;
                if (accept) begin
                    data_d[0] = in_data;
                end
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (go[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

`ifdef PIPE_REG_OCC_EN
    logic             emit;
    logic [CNT_W-1:0] occ_q, occ_d;

    assign emit = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !emit) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && emit) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed table and sequences on DEPTH=4, plus
// randomized runs on DEPTH 1/2/7/4 against a word-position queue model.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;
    int unsigned rnd_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- directed DUT, DEPTH = 4 ----------------
    logic        d_rst, d_fl, d_iv, d_ordy, d_ir, d_ov;
    logic [15:0] d_id, d_od;
`ifdef PIPE_REG_OCC_EN
    logic [2:0]  d_occ;
`endif

    pipe_reg_chain #(.WIDTH(16), .DEPTH(4)) u_dir (
        .clk(clk), .rst(d_rst), .flush(d_fl),
        .in_valid(d_iv), .in_data(d_id), .in_ready(d_ir),
        .out_valid(d_ov), .out_data(d_od), .out_ready(d_ordy)
`ifdef PIPE_REG_OCC_EN
        , .occ(d_occ)
`endif
    );

    task automatic drive(input logic fl, input logic iv, input logic [15:0] id, input logic ordy);
        @(negedge clk);
        d_fl = fl; d_iv = iv; d_id = id; d_ordy = ordy;
        #1;
    endtask

    task automatic chk_occ(input string nm, input int exp);
`ifdef PIPE_REG_OCC_EN
        chk(nm, 32'(d_occ), 32'(exp));
`endif
    endtask

    typedef struct {
        logic        fl, iv;
        logic [15:0] id;
        logic        ordy;
        logic        e_ir, e_ov;
        logic [15:0] e_od;
        int          e_occ;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic fl, input logic iv, input logic [15:0] id, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [15:0] e_od, input int e_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        tbl.push_back(v);
    endtask

    // ---------------- randomized DUTs ----------------
    logic r_rst;

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 7 : 4;
        logic        fl, iv, ordy, ir, ov;
        logic [15:0] id, od;
`ifdef PIPE_REG_OCC_EN
        logic [$clog2(D+1)-1:0] oc;
`endif
        pipe_reg_chain #(.WIDTH(16), .DEPTH(D)) u_dut (
            .clk(clk), .rst(r_rst), .flush(fl),
            .in_valid(iv), .in_data(id), .in_ready(ir),
            .out_valid(ov), .out_data(od), .out_ready(ordy)
`ifdef PIPE_REG_OCC_EN
            , .occ(oc)
`endif
        );

        // Each queued word carries the stage it currently occupies.
        typedef struct { logic [15:0] d; int pos; } ent_t;
        ent_t        q[$];
        logic [15:0] top;

        initial begin
            bit e_ir, e_ov, acc, emit;
            int lim, np;
            fl = 1'b0; iv = 1'b0; ordy = 1'b0; id = '0; top = '0;
            wait (r_rst === 1'b1);
            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                fl   = ($urandom_range(0, 49) == 0);
                iv   = 1'($urandom_range(0, 1));
                ordy = 1'($urandom_range(0, 1));
                id   = 16'($urandom);
                #1;
                e_ov = !fl && q.size() > 0 && q[0].pos == D - 1;
                e_ir = !fl && (q.size() < D || ordy);
                chk("rnd_in_ready", 32'(ir), 32'(e_ir));
                chk("rnd_out_valid", 32'(ov), 32'(e_ov));
                chk("rnd_out_data", 32'(od), 32'(top));
`ifdef PIPE_REG_OCC_EN
                chk("rnd_occ", 32'(oc), 32'(q.size()));
`endif
                acc  = iv && e_ir;
                emit = e_ov && ordy;
                @(posedge clk);
                if (fl) begin
                    q.delete();
                end else begin
                    if (emit) void'(q.pop_front());
                    lim = D - 1;
                    foreach (q[k]) begin
                        np = (q[k].pos + 1 > lim) ? lim : q[k].pos + 1;
                        q[k].pos = np;
                        lim = np - 1;
                    end
                    if (acc) q.push_back('{d: id, pos: 0});
                    if (q.size() > 0 && q[0].pos == D - 1) top = q[0].d;
                end
            end
            rnd_done++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        d_rst = 1'b0; r_rst = 1'b0;
        d_fl = 1'b0; d_iv = 1'b0; d_id = '0; d_ordy = 1'b0;

        // stall fill, drain with concurrent entry, then flush
        add(0,1,16'hA000,0, 1,0,16'h0000,0);
        add(0,1,16'hA001,0, 1,0,16'h0000,1);
        add(0,1,16'hA002,0, 1,0,16'h0000,2);
        add(0,1,16'hA003,0, 1,0,16'h0000,3);
        add(0,1,16'hA004,0, 0,1,16'hA000,4);
        add(0,1,16'hA004,0, 0,1,16'hA000,4);
        add(0,1,16'hA004,1, 1,1,16'hA000,4);
        add(0,1,16'hA005,1, 1,1,16'hA001,4);
        add(0,0,16'h0000,1, 1,1,16'hA002,4);
        add(0,0,16'h0000,1, 1,1,16'hA003,3);
        add(0,0,16'h0000,1, 1,1,16'hA004,2);
        add(0,0,16'h0000,1, 1,1,16'hA005,1);
        add(0,0,16'h0000,1, 1,0,16'hA005,0);
        add(0,1,16'hB000,0, 1,0,16'hA005,0);
        add(0,1,16'hB001,0, 1,0,16'hA005,1);
        add(0,1,16'hB002,0, 1,0,16'hA005,2);
        add(0,0,16'h0000,0, 1,0,16'hA005,3);
        add(1,1,16'hC000,1, 0,0,16'hB000,3);
        add(0,1,16'h5555,1, 1,0,16'hB000,0);
        add(0,0,16'h0000,1, 1,0,16'hB000,1);
        add(0,0,16'h0000,1, 1,0,16'hB000,1);
        add(0,0,16'h0000,1, 1,0,16'hB000,1);
        add(0,0,16'h0000,1, 1,1,16'h5555,1);
        add(0,0,16'h0000,1, 1,0,16'h5555,0);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(d_ov), 32'(0));
        chk("reset_out_data", 32'(d_od), 32'(0));
        chk_occ("reset_occ", 0);
        d_rst = 1'b1; r_rst = 1'b1;
        #1;
        chk("idle_in_ready", 32'(d_ir), 32'(1));

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), 32'(d_ir), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(d_ov), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 32'(d_od), 32'(tbl[i].e_od));
            chk_occ($sformatf("tbl%0d_occ", i), tbl[i].e_occ);
        end

        // streaming: 16 back-to-back words, first output 4 cycles after first accept
        for (int c = 0; c < 23; c++) begin
            drive(1'b0, c < 16, 16'(c + 1), 1'b1);
            chk("stream_in_ready", 32'(d_ir), 32'(1));
            chk("stream_out_valid", 32'(d_ov), 32'(c >= 4 && c < 20));
            if (c >= 4 && c < 20) chk("stream_out_data", 32'(d_od), 32'(c - 3));
        end

        // bubble collapse: a lone word migrates to the output end under stall
        drive(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("bubble_in_ready0", 32'(d_ir), 32'(1));
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0);
            chk("bubble_in_ready", 32'(d_ir), 32'(1));
            chk("bubble_out_valid", 32'(d_ov), 32'(c >= 4));
            if (c >= 4) chk("bubble_out_data", 32'(d_od), 32'h1234);
            chk_occ("bubble_occ", 1);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("bubble_drain_valid", 32'(d_ov), 32'(1));
        chk("bubble_drain_data", 32'(d_od), 32'h1234);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("bubble_empty_valid", 32'(d_ov), 32'(0));
        chk_occ("bubble_empty_occ", 0);

        // asynchronous reset with three words held
        drive(1'b0, 1'b1, 16'h7001, 1'b0);
        drive(1'b0, 1'b1, 16'h7002, 1'b0);
        drive(1'b0, 1'b1, 16'h7003, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("prerst_out_valid", 32'(d_ov), 32'(1));
        chk("prerst_out_data", 32'(d_od), 32'h7001);
        chk_occ("prerst_occ", 3);
        #2;
        d_rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(d_ov), 32'(0));
        chk("midrst_out_data", 32'(d_od), 32'(0));
        chk_occ("midrst_occ", 0);
        @(negedge clk);
        @(negedge clk);
        d_rst = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(d_ir), 32'(1));
        chk("postrst_out_valid", 32'(d_ov), 32'(0));

        for (int c = 0; c < 12000 && rnd_done < 4; c++) @(negedge clk);
        chk("rnd_complete", rnd_done, 32'(4));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
